// File: rtl/adder_operand_loader.sv
// Byte-stream operand loader for the ALU adder: assembles x then y (little-endian),
// holds the pair behind a valid/ready handshake and counts delivered pairs.
module adder_operand_loader #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {LOAD_X, LOAD_Y, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, handshake, last_byte;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready && !abort;
  assign last_byte = (idx_q == IDX_W'(NB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_X;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    // abort leaves x/y contents alone; only the sequencing restarts
    if (abort) begin
      state_d = LOAD_X;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD_X: if (accept) begin
          for (int b = 0; b < NB; b++)
            if (idx_q == IDX_W'(b)) x_d[b*8 +: 8] = in_data;
          if (last_byte) begin
            state_d = LOAD_Y;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        LOAD_Y: if (accept) begin
          for (int b = 0; b < NB; b++)
            if (idx_q == IDX_W'(b)) y_d[b*8 +: 8] = in_data;
          if (last_byte) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        HOLD: if (handshake) begin
          state_d = LOAD_X;
          idx_d   = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = LOAD_X;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = !rst && !abort && (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  assign out_x    = x_q;
  assign out_y    = y_q;
  assign pair_cnt = cnt_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader: expected pairs queued at send time,
// popped and compared whenever the output handshake fires.
module tb_adder_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pair_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  adder_operand_loader #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_ready(out_ready), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // handshake monitor: inputs and outputs are stable at the falling edge
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready && !abort && !rst) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pair", {out_x, out_y}, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("pair_x", {16'h0, out_x}, {16'h0, e[31:16]});
        chk("pair_y", {16'h0, out_y}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit got;
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("byte_accept_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic send_pair(input logic [15:0] x, input logic [15:0] y,
                           input int max_gap, input bit expect_out);
    send_byte(x[7:0],  max_gap);
    send_byte(x[15:8], max_gap);
    send_byte(y[7:0],  max_gap);
    send_byte(y[15:8], max_gap);
    if (expect_out) sb_q.push_back({x, y});
  endtask

  initial begin
    logic [15:0] hx, hy;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_x",     {16'h0, out_x},     32'h0);
    chk("rst_out_y",     {16'h0, out_y},     32'h0);
    chk("rst_pair_cnt",  {24'h0, pair_cnt},  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: back-to-back pair, consumer ready
    out_ready = 1'b1;
    send_pair(16'h1234, 16'h5678, 0, 1'b1);
    @(negedge clk);
    chk("t1_valid_hi", {31'h0, out_valid}, 32'h1);
    chk("t1_x",        {16'h0, out_x},     32'h1234);
    chk("t1_y",        {16'h0, out_y},     32'h5678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_valid_lo", {31'h0, out_valid}, 32'h0);
    chk("t1_cnt",      {24'h0, pair_cnt},  32'h1);
    chk("t1_in_ready", {31'h0, in_ready},  32'h1);
    @(posedge clk); #1;

    // 2: held pair under backpressure, extra bytes ignored
    out_ready = 1'b0;
    send_pair(16'h2211, 16'h4433, 0, 1'b1);
    hx = out_x; hy = out_y;
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid_held", {31'h0, out_valid}, 32'h1);
      chk("t2_in_ready",   {31'h0, in_ready},  32'h0);
      chk("t2_xy_stable",  {out_x, out_y},     {hx, hy});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_valid_lo", {31'h0, out_valid}, 32'h0);
    chk("t2_cnt",      {24'h0, pair_cnt},  32'h2);
    @(posedge clk); #1;

    // 3: abort mid-operand, byte presented alongside abort is refused
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hAA, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    chk("t3_abort_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    send_pair(16'h0001, 16'h0002, 0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_cnt", {24'h0, pair_cnt}, 32'h3);
    @(posedge clk); #1;

    // 4: abort coincident with out_ready in HOLD drops the pair
    out_ready = 1'b0;
    send_pair(16'h5555, 16'h6666, 0, 1'b0);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t4_valid_lo", {31'h0, out_valid}, 32'h0);
    chk("t4_cnt",      {24'h0, pair_cnt},  32'h3);
    chk("t4_x_kept",   {16'h0, out_x},     32'h5555);
    @(posedge clk); #1;

    // 5: async reset mid-pair
    out_ready = 1'b1;
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    #3 rst = 1'b1;
    #1;
    chk("t5_x",        {16'h0, out_x},     32'h0);
    chk("t5_y",        {16'h0, out_y},     32'h0);
    chk("t5_valid",    {31'h0, out_valid}, 32'h0);
    chk("t5_cnt",      {24'h0, pair_cnt},  32'h0);
    chk("t5_in_ready", {31'h0, in_ready},  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_pair(16'hBEEF, 16'hCAFE, 0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_cnt_after", {24'h0, pair_cnt}, 32'h1);
    @(posedge clk); #1;

    // 6: 255 more pairs with random gaps wraps the counter from 1 to 0
    for (int p = 0; p < 255; p++) begin
      send_pair(16'($urandom), 16'($urandom), 2, 1'b1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_cnt_wrap", {24'h0, pair_cnt},  32'h0);
    chk("t6_sb_empty", 32'(sb_q.size()),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
